// File: rtl/sys_bus_pkg.sv
// sys_bus_pkg: shared FSM state, slot geometry and peripheral slot map for the system bus
package sys_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } bus_state_t;

    localparam int NUM_SLOTS_DEF = 8;
    localparam int SLOT_W        = 8;

    localparam int SLOT_EXT_MEM = 0;
    localparam int SLOT_PS2     = 3;
    localparam int SLOT_VGA     = 7;

    function automatic logic [SLOT_W-1:0] slot_of(input logic [31:0] addr);
        return addr[31:32-SLOT_W];
    endfunction

endpackage

// File: rtl/bus_rr_arb.sv
// bus_rr_arb: two-requester round-robin arbiter with one-hot grant
//   clk, rst : clock, synchronous active-high reset (priority returns to req[0])
//   req      : request vector
//   upd      : commit the current grant this cycle and rotate priority
//   gnt      : one-hot grant, combinational from req and priority
module bus_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    logic pri1;

    always_comb begin
        gnt[0] = req[0] & (~pri1 | ~req[1]);
        gnt[1] = req[1] & (pri1 | ~req[0]);
    end

    // The master that just won loses priority on the next contested request.
    always_ff @(posedge clk) begin
        if (rst)
            pri1 <= 1'b0;
        else if (upd && |req)
            pri1 <= gnt[0];
    end

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: two-master single-outstanding bus arbiter with slot decode and slave timeout
//   clk_i, rst_i         : clock, synchronous active-high reset
//   m*_req/we/be/addr/wd : master request and access fields, held until that master's ready
//   m*_rd/ready/err      : one-cycle completion pulse with read data and error flag
//   s_req_o              : one-hot slave request, slot = addr[31:24]
//   s_we/be/wd/addr_o    : latched access fields, address with slot byte stripped
//   s_rd_i, s_ready_i    : flattened per-slot read data and per-slot completion
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int NUM_SLOTS      = NUM_SLOTS_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [3:0]              m0_be_i,
    input  logic [31:0]             m0_addr_i,
    input  logic [31:0]             m0_wd_i,
    output logic [31:0]             m0_rd_o,
    output logic                    m0_ready_o,
    output logic                    m0_err_o,
    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [3:0]              m1_be_i,
    input  logic [31:0]             m1_addr_i,
    input  logic [31:0]             m1_wd_i,
    output logic [31:0]             m1_rd_o,
    output logic                    m1_ready_o,
    output logic                    m1_err_o,
    output logic [NUM_SLOTS-1:0]    s_req_o,
    output logic                    s_we_o,
    output logic [3:0]              s_be_o,
    output logic [31:0]             s_wd_o,
    output logic [31:0]             s_addr_o,
    input  logic [32*NUM_SLOTS-1:0] s_rd_i,
    input  logic [NUM_SLOTS-1:0]    s_ready_i
);

    localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    bus_state_t state, state_nx;

    logic [1:0]        req, gnt, gnt_q;
    logic              sel_we, dec_err, take, hit, tmo;
    logic [3:0]        sel_be;
    logic [31:0]       sel_addr, sel_wd;
    logic [SLOT_W-1:0] sel_slot;

    logic              we_q, err_q;
    logic [3:0]        be_q;
    logic [23:0]       addr_q;
    logic [SW-1:0]     slot_q;
    logic [31:0]       wd_q, rd_q;
    logic [CW-1:0]     cnt_q;

    logic [31:0] s_word [NUM_SLOTS];

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_word
        assign s_word[k] = s_rd_i[32*k +: 32];
    end

    assign req  = {m1_req_i, m0_req_i};
    assign take = state == ST_IDLE;

    bus_rr_arb u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (req),
        .upd (take),
        .gnt (gnt)
    );

    always_comb begin
        sel_we   = gnt[1] ? m1_we_i   : m0_we_i;
        sel_be   = gnt[1] ? m1_be_i   : m0_be_i;
        sel_addr = gnt[1] ? m1_addr_i : m0_addr_i;
        sel_wd   = gnt[1] ? m1_wd_i   : m0_wd_i;
        sel_slot = slot_of(sel_addr);
        dec_err  = int'(sel_slot) >= NUM_SLOTS;
        // Only the addressed slave's ready counts; the rest of the vector is noise.
        hit      = s_ready_i[slot_q];
        tmo      = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:   if (|req) state_nx = dec_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (hit || tmo) state_nx = ST_RESP;
            ST_RESP:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Access fields are captured once at grant, so masters may change
    // or drop their inputs afterwards without disturbing the access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q  <= '0;
            we_q   <= 1'b0;
            be_q   <= '0;
            addr_q <= '0;
            slot_q <= '0;
            wd_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (take && |req) begin
            gnt_q  <= gnt;
            we_q   <= sel_we;
            be_q   <= sel_be;
            addr_q <= sel_addr[23:0];
            slot_q <= sel_slot[SW-1:0];
            wd_q   <= sel_wd;
            rd_q   <= '0;
            err_q  <= dec_err;
            cnt_q  <= '0;
        end else if (state == ST_ACCESS) begin
            cnt_q <= cnt_q + 1'b1;
            if (hit)
                rd_q <= we_q ? '0 : s_word[slot_q];
            else if (tmo)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        s_req_o    = state == ST_ACCESS ? NUM_SLOTS'(1) << slot_q : '0;
        s_we_o     = we_q;
        s_be_o     = be_q;
        s_wd_o     = wd_q;
        s_addr_o   = {8'h00, addr_q};
        m0_ready_o = state == ST_RESP && gnt_q[0];
        m1_ready_o = state == ST_RESP && gnt_q[1];
        m0_err_o   = m0_ready_o && err_q;
        m1_err_o   = m1_ready_o && err_q;
        m0_rd_o    = m0_ready_o ? rd_q : '0;
        m1_rd_o    = m1_ready_o ? rd_q : '0;
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed literal checks plus randomized traffic against a transaction-level model
module tb_sys_bus_arbiter;

    localparam int TO = 16;
    localparam int NS = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          m0_req_i = 1'b0, m0_we_i = 1'b0, m1_req_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]    m0_be_i = '0, m1_be_i = '0;
    logic [31:0]   m0_addr_i = '0, m0_wd_i = '0, m1_addr_i = '0, m1_wd_i = '0;
    logic [31:0]   m0_rd_o, m1_rd_o, s_wd_o, s_addr_o;
    logic          m0_ready_o, m0_err_o, m1_ready_o, m1_err_o, s_we_o;
    logic [NS-1:0] s_req_o;
    logic [3:0]    s_be_o;
    logic [32*NS-1:0] s_rd_i = '0;
    logic [NS-1:0] s_ready_i = '0;

    always #5 clk_i = ~clk_i;

    sys_bus_arbiter #(.TIMEOUT_CYCLES(TO), .NUM_SLOTS(NS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_o), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_o), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wd_o(s_wd_o),
        .s_addr_o(s_addr_o), .s_rd_i(s_rd_i), .s_ready_i(s_ready_i)
    );

    int total = 0;
    int bad = 0;

    // Transaction-level model: one outstanding transaction record plus the round-robin preference.
    bit          md_acc = 0, md_resp = 0, md_pref1 = 0, md_we = 0, md_err = 0;
    int          md_owner = 0, md_cnt = 0;
    logic [3:0]  md_be = '0;
    logic [31:0] md_addr = '0, md_wd = '0, md_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_cycle();
        int   slot;
        logic [7:0] esreq;
        slot  = int'(md_addr[31:24]);
        esreq = md_acc ? 8'(1 << slot) : 8'h00;
        chk("s_req", 32'(s_req_o), 32'(esreq));
        chk("m0_ready", 32'(m0_ready_o), 32'(md_resp && md_owner == 0));
        chk("m1_ready", 32'(m1_ready_o), 32'(md_resp && md_owner == 1));
        chk("m0_err", 32'(m0_err_o), 32'(md_resp && md_owner == 0 && md_err));
        chk("m1_err", 32'(m1_err_o), 32'(md_resp && md_owner == 1 && md_err));
        chk("m0_rd", m0_rd_o, (md_resp && md_owner == 0) ? md_rd : 32'h0);
        chk("m1_rd", m1_rd_o, (md_resp && md_owner == 1) ? md_rd : 32'h0);
        if (md_acc) begin
            chk("s_addr", s_addr_o, {8'h00, md_addr[23:0]});
            chk("s_wd", s_wd_o, md_wd);
            chk("s_we", 32'(s_we_o), 32'(md_we));
            chk("s_be", 32'(s_be_o), 32'(md_be));
        end
        if (rst_i) begin
            md_acc = 0; md_resp = 0; md_pref1 = 0;
        end else if (md_resp) begin
            md_resp = 0;
        end else if (md_acc) begin
            md_cnt++;
            if (s_ready_i[slot]) begin
                md_rd = md_we ? 32'h0 : s_rd_i[32*slot +: 32];
                md_acc = 0; md_resp = 1;
            end else if (md_cnt == TO) begin
                md_rd = 0; md_err = 1; md_acc = 0; md_resp = 1;
            end
        end else if (m0_req_i || m1_req_i) begin
            md_owner = (m0_req_i && m1_req_i) ? int'(md_pref1) : (m1_req_i ? 1 : 0);
            md_pref1 = md_owner == 0;
            md_we   = md_owner == 1 ? m1_we_i   : m0_we_i;
            md_be   = md_owner == 1 ? m1_be_i   : m0_be_i;
            md_addr = md_owner == 1 ? m1_addr_i : m0_addr_i;
            md_wd   = md_owner == 1 ? m1_wd_i   : m0_wd_i;
            md_cnt  = 0;
            md_err  = 0;
            md_rd   = 0;
            if (int'(md_addr[31:24]) >= NS) begin
                md_err = 1; md_resp = 1;
            end else
                md_acc = 1;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        model_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input int k, input logic rq, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (k == 0) begin
            m0_req_i = rq; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wd_i = wd;
        end else begin
            m1_req_i = rq; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wd_i = wd;
        end
    endtask

    task automatic rand_rd();
        for (int i = 0; i < NS; i++) s_rd_i[32*i +: 32] = $urandom;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        step();
        rst_i = 1'b0;
    endtask

    bit          pend [2];
    bit          sl_act = 0, hit;
    int          sl_cnt = 0, sl_wait = 0, n, seq [4];
    logic [7:0]  slot, noise;
    logic [31:0] ra;

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        do_reset();
        chk("reset s_req", 32'(s_req_o), 32'h0);
        chk("reset s_addr", s_addr_o, 32'h0);
        chk("reset m0_ready", 32'(m0_ready_o), 32'h0);

        // m0 write to slot 0, slave ready immediately
        rand_rd();
        set_m(0, 1, 1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D);
        s_ready_i = 8'h01;
        step();
        chk("wr s_req", 32'(s_req_o), 32'h01);
        chk("wr s_addr", s_addr_o, 32'h10);
        chk("wr s_wd", s_wd_o, 32'hCAFE_F00D);
        chk("wr m0_ready early", 32'(m0_ready_o), 32'h0);
        step();
        chk("wr m0_ready", 32'(m0_ready_o), 32'h1);
        chk("wr m0_err", 32'(m0_err_o), 32'h0);
        chk("wr m0_rd", m0_rd_o, 32'h0);
        chk("wr m1_ready", 32'(m1_ready_o), 32'h0);
        set_m(0, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        step();
        chk("wr ready single", 32'(m0_ready_o), 32'h0);

        // simultaneous back-to-back requests alternate starting with m0
        do_reset();
        set_m(0, 1, 0, 4'hF, 32'h0000_0020, 0);
        set_m(1, 1, 0, 4'hF, 32'h0100_0008, 0);
        s_ready_i = 8'h03;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            step();
            if (m0_ready_o || m1_ready_o) begin
                chk("rr one master", 32'(m0_ready_o & m1_ready_o), 32'h0);
                seq[n] = int'(m1_ready_o);
                n++;
                if (n == 4) begin
                    m0_req_i = 0; m1_req_i = 0;
                end
            end
        end
        chk("rr count", n, 4);
        for (int i = 0; i < 4; i++) chk("rr order", seq[i], i % 2);
        s_ready_i = '0;
        step();
        chk("rr ready single", 32'({m1_ready_o, m0_ready_o}), 32'h0);

        // m1 read of slot 3 with three wait cycles
        do_reset();
        rand_rd();
        s_rd_i[96 +: 32] = 32'h0000_001C;
        set_m(1, 1, 0, 4'hF, 32'h0300_0004, 0);
        step();
        chk("rd3 s_req", 32'(s_req_o), 32'h08);
        chk("rd3 s_addr", s_addr_o, 32'h4);
        step();
        step();
        step();
        chk("rd3 s_req held", 32'(s_req_o), 32'h08);
        chk("rd3 early ready", 32'(m1_ready_o), 32'h0);
        s_ready_i = 8'h08;
        step();
        chk("rd3 m1_ready", 32'(m1_ready_o), 32'h1);
        chk("rd3 m1_rd", m1_rd_o, 32'h1C);
        chk("rd3 m1_err", 32'(m1_err_o), 32'h0);
        chk("rd3 m0_ready", 32'(m0_ready_o), 32'h0);
        set_m(1, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        step();

        // decode error
        do_reset();
        set_m(0, 1, 0, 4'hF, 32'h0900_0000, 0);
        s_ready_i = 8'hFF;
        step();
        chk("dec s_req", 32'(s_req_o), 32'h0);
        chk("dec m0_ready", 32'(m0_ready_o), 32'h1);
        chk("dec m0_err", 32'(m0_err_o), 32'h1);
        chk("dec m0_rd", m0_rd_o, 32'h0);
        set_m(0, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        step();

        // timeout on slot 7
        do_reset();
        rand_rd();
        set_m(0, 1, 0, 4'hF, 32'h0700_0000, 0);
        s_ready_i = 8'h7F;
        n = 0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            step();
            if (s_req_o == 8'h80) n++;
            if (m0_ready_o) begin
                hit = 1;
                chk("tmo err", 32'(m0_err_o), 32'h1);
                chk("tmo rd", m0_rd_o, 32'h0);
            end
        end
        chk("tmo done", 32'(hit), 32'h1);
        chk("tmo s_req cycles", n, 16);
        set_m(0, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        step();

        // reset two cycles into an access
        do_reset();
        set_m(0, 1, 0, 4'hF, 32'h0100_0000, 0);
        step();
        step();
        rst_i = 1;
        step();
        rst_i = 0;
        chk("rst s_req", 32'(s_req_o), 32'h0);
        chk("rst ready", 32'({m1_ready_o, m0_ready_o}), 32'h0);
        set_m(0, 1, 0, 4'hF, 32'h0000_0020, 0);
        set_m(1, 1, 0, 4'hF, 32'h0000_0040, 0);
        s_ready_i = 8'h01;
        step();
        chk("rst no ready", 32'({m1_ready_o, m0_ready_o}), 32'h0);
        step();
        chk("rst m0 wins", 32'(m0_ready_o), 32'h1);
        chk("rst m1 waits", 32'(m1_ready_o), 32'h0);
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        step();

        // randomized traffic
        pend[0] = 0;
        pend[1] = 0;
        for (int c = 0; c < 5000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k] && (k == 1 ? m1_ready_o : m0_ready_o)) pend[k] = 0;
                if (!pend[k]) begin
                    ra = $urandom_range(0, 11);
                    slot = ra <= 9 ? ra[7:0] : 8'hC3;
                    ra = $urandom;
                    if ($urandom_range(0, 1) == 0) begin
                        pend[k] = 1;
                        set_m(k, 1, 1'($urandom), 4'($urandom), {slot, ra[23:0]}, $urandom);
                    end else
                        set_m(k, 0, 1'($urandom), 4'($urandom), {slot, ra[23:0]}, $urandom);
                end else if (md_acc && md_owner == k && $urandom_range(0, 1) == 0)
                    set_m(k, 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom);
            end
            if (s_req_o != '0) begin
                if (!sl_act) begin
                    sl_act = 1;
                    sl_cnt = 0;
                    sl_wait = $urandom_range(0, 7) == 0 ? 1000 : int'($urandom_range(0, 4));
                end
                hit = sl_cnt == sl_wait;
                sl_cnt++;
            end else begin
                sl_act = 0;
                hit = 0;
            end
            noise = 8'($urandom);
            s_ready_i = (noise & ~s_req_o) | (hit ? s_req_o : 8'h00);
            rand_rd();
            rst_i = $urandom_range(0, 599) == 0;
            step();
        end

        rst_i = 0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_ready_i = '0;
        repeat (TO + 4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles a slave may hold an access before error termination.
REQ-002 SHALL have parameter NUM_SLOTS, default 8, number of decoded slave slots (slot = addr[31:24]).
REQ-003 SHALL have clk_i, input, 1: single system clock, all logic on rising edge.
REQ-004 SHALL have rst_i, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have m0_req_i/m1_req_i, input, 1 each: master request, held until that master's ready.
REQ-006 SHALL have m0_we_i/m1_we_i, input, 1 each: write enable.
REQ-007 SHALL have m0_be_i/m1_be_i, input, 4 each: byte enables.
REQ-008 SHALL have m0_addr_i/m1_addr_i, input, 32 each: byte address.
REQ-009 SHALL have m0_wd_i/m1_wd_i, input, 32 each: write data.
REQ-010 SHALL have m0_rd_o/m1_rd_o, output, 32 each: read data, valid while ready high.
REQ-011 SHALL have m0_ready_o/m1_ready_o, output, 1 each: one-cycle completion pulse.
REQ-012 SHALL have m0_err_o/m1_err_o, output, 1 each: error flag, valid while ready high.
REQ-013 SHALL have s_req_o, output, NUM_SLOTS: one-hot slave request.
REQ-014 SHALL have s_we_o, output, 1; s_be_o, output, 4; s_wd_o, output, 32: latched write controls/data.
REQ-015 SHALL have s_addr_o, output, 32: {8'b0, addr[23:0]} of latched address.
REQ-016 SHALL have s_rd_i, input, 32*NUM_SLOTS: flattened slave read data, slot k at bits [32k+31:32k].
REQ-017 SHALL have s_ready_i, input, NUM_SLOTS: per-slave completion.

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, plus IDLE -> RESP for decode error.
REQ-019 IDLE: if any req, SHALL grant one master, latch its we/be/addr/wd into registers, next state ACCESS (or RESP if slot >= NUM_SLOTS).
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests the master not granted last wins; after reset m0 wins.
REQ-021 ACCESS: s_req_o[slot] SHALL be high every cycle until s_ready_i[slot]=1, other s_req_o bits low.
REQ-022 On s_ready_i[slot] in ACCESS SHALL latch s_rd_i slot word into read register, next state RESP.
REQ-023 RESP: granted master's ready_o SHALL be high exactly one cycle; rd_o = latched data (0 for writes/errors); non-granted master ready_o/err_o low; rd_o of non-granted master 0.
REQ-024 Minimum latency: req sampled in IDLE at cycle N, slave ready at N+1 -> ready_o at N+2.
REQ-025 Decode error (addr[31:24] >= NUM_SLOTS): no s_req_o, ready_o with err_o=1 and rd_o=0 at N+1.
REQ-026 Timeout: counter cleared on ACCESS entry, +1 per ACCESS cycle; at TIMEOUT_CYCLES without ready, drop s_req_o, RESP with err_o=1, rd_o=0.
REQ-027 s_ready_i on non-selected slots and outside ACCESS SHALL be ignored.
REQ-028 Master inputs changing after grant SHALL not affect the ongoing access; req deassertion mid-access does not abort.
REQ-029 req high in the cycle after ready_o SHALL be treated as a new transaction.

Reset
REQ-030 rst_i high at a clock edge SHALL force IDLE, rr pointer to m0, counter 0, all outputs and latched registers 0.
REQ-031 Reset mid-ACCESS SHALL abort: s_req_o low from next cycle, no ready_o pulse generated.

Structure
REQ-032 Package sys_bus_pkg SHALL hold the FSM state enum, NUM_SLOTS default, SLOT_W=8, and the slot-to-peripheral constants (ext mem 0, ps2 3, vga 7).
REQ-033 Round-robin grant logic SHALL be one sub-module bus_rr_arb (2 requests in, one-hot grant out, update on grant).

Verification
REQ-034 m0 write addr 0x0000_0010, be 4'hF, wd 0xCAFE_F00D, slot0 ready same cycle -> s_req_o=8'h01, s_addr_o=0x10 at N+1, m0_ready_o at N+2, err 0.
REQ-035 m0,m1 req same cycle, back-to-back -> order m0,m1,m0,m1; each ready pulse single-cycle to correct master only.
REQ-036 m1 read 0x0300_0004, slot3 returns 0x0000_001C after 3 wait cycles -> s_addr_o=0x4, m1_rd_o=0x1C, ready at N+5.
REQ-037 m0 read 0x0900_0000 -> no s_req_o, m0_ready_o and m0_err_o at N+1, rd 0.
REQ-038 slot7 never ready -> s_req_o held exactly 16 cycles, then ready_o with err_o=1, rd 0.
REQ-039 rst_i asserted 2 cycles into an ACCESS -> s_req_o 0 next cycle, no ready_o, next simultaneous request granted to m0.
